// File: rtl/i2c_target_responder.sv
// I2C target: oversampled SCL/SDA, START/STOP detection, 7-bit address match,
// byte capture on writes and byte return from tx_data on reads.
module i2c_target_responder #(
   parameter logic [6:0]  ADDR        = 7'h27,
   parameter int unsigned HOLD_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i2c_sclk,
   inout  wire        i2c_sdat,
   input  logic [7:0] tx_data,
   output logic       tx_req,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       busy,
   output logic       rw
);

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_ADDR     = 3'd1;
   localparam logic [2:0] ST_ADDR_ACK = 3'd2;
   localparam logic [2:0] ST_WR_BYTE  = 3'd3;
   localparam logic [2:0] ST_WR_ACK   = 3'd4;
   localparam logic [2:0] ST_RD_BYTE  = 3'd5;
   localparam logic [2:0] ST_RD_ACK   = 3'd6;
   localparam logic [2:0] ST_IGNORE   = 3'd7;

   localparam int unsigned HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int unsigned HOLD_LOAD = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;

   logic          scl_s1_q, scl_s2_q, scl_prev_q;
   logic          sda_s1_q, sda_s2_q, sda_prev_q;
   logic          scl_rise, scl_fall, start_det, stop_det;
   logic          hold_pend_q;
   logic [HW-1:0] hold_cnt_q;
   logic          hold_done;

   logic [2:0] state_q, state_d;
   logic [3:0] cnt_q, cnt_d, cnt_inc;
   logic [6:0] sh_q, sh_d;
   logic [7:0] tx_sh_q, tx_sh_d;
   logic [7:0] rx_data_d;
   logic       sda_drv_q, sda_drv_d;
   logic       busy_d, rw_d, rx_valid_d, tx_req_d;
   logic       ack_q, ack_d;
   logic       load_tx;

   assign i2c_sdat = sda_drv_q ? 1'b0 : 1'bz;

   // Sync flops reset to the idle-bus level so no edge is seen coming out of reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scl_s1_q   <= 1'b1;
         scl_s2_q   <= 1'b1;
         scl_prev_q <= 1'b1;
         sda_s1_q   <= 1'b1;
         sda_s2_q   <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_s1_q   <= i2c_sclk;
         scl_s2_q   <= scl_s1_q;
         scl_prev_q <= scl_s2_q;
         sda_s1_q   <= i2c_sdat;
         sda_s2_q   <= sda_s1_q;
         sda_prev_q <= sda_s2_q;
      end
   end

   assign scl_rise  = scl_s2_q & ~scl_prev_q;
   assign scl_fall  = ~scl_s2_q & scl_prev_q;
   // SCL high on either side of the SDA edge, so START/STOP wins over a coincident SCL edge.
   assign start_det = (scl_s2_q | scl_prev_q) & sda_prev_q & ~sda_s2_q;
   assign stop_det  = (scl_s2_q | scl_prev_q) & ~sda_prev_q & sda_s2_q;
   assign hold_done = hold_pend_q && (hold_cnt_q == '0);
   assign cnt_inc   = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_pend_q <= 1'b0;
         hold_cnt_q  <= '0;
      end else if (start_det || stop_det) begin
         hold_pend_q <= 1'b0;
      end else if (scl_fall) begin
         hold_pend_q <= 1'b1;
         hold_cnt_q  <= HW'(HOLD_LOAD);
      end else if (hold_pend_q) begin
         if (hold_cnt_q == '0) hold_pend_q <= 1'b0;
         else                  hold_cnt_q  <= hold_cnt_q - 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sh_d       = sh_q;
      tx_sh_d    = tx_sh_q;
      rx_data_d  = rx_data;
      sda_drv_d  = sda_drv_q;
      busy_d     = busy;
      rw_d       = rw;
      ack_d      = ack_q;
      rx_valid_d = 1'b0;
      tx_req_d   = 1'b0;
      load_tx    = 1'b0;
      if (start_det) begin
         state_d   = ST_ADDR;
         cnt_d     = 4'd0;
         sda_drv_d = 1'b0;
      end else if (stop_det) begin
         state_d   = ST_IDLE;
         sda_drv_d = 1'b0;
         busy_d    = 1'b0;
      end else begin
         case (state_q)
            ST_ADDR: if (scl_rise) begin
               sh_d  = {sh_q[5:0], sda_s2_q};
               cnt_d = cnt_inc;
               if (cnt_q == 4'd7) begin
                  cnt_d = 4'd0;
                  if (sh_q == ADDR) begin
                     busy_d  = 1'b1;
                     rw_d    = sda_s2_q;
                     state_d = ST_ADDR_ACK;
                  end else begin
                     busy_d  = 1'b0;
                     state_d = ST_IGNORE;
                  end
               end
            end
            // First hold after entry drives the ACK low, the next one ends the ACK clock.
            ST_ADDR_ACK, ST_WR_ACK: if (hold_done) begin
               if (!sda_drv_q) begin
                  sda_drv_d = 1'b1;
               end else if (state_q == ST_WR_ACK || !rw) begin
                  sda_drv_d = 1'b0;
                  cnt_d     = 4'd0;
                  state_d   = ST_WR_BYTE;
               end else begin
                  load_tx = 1'b1;
               end
            end
            ST_WR_BYTE: if (scl_rise) begin
               sh_d  = {sh_q[5:0], sda_s2_q};
               cnt_d = cnt_inc;
               if (cnt_q == 4'd7) begin
                  rx_data_d  = {sh_q, sda_s2_q};
                  rx_valid_d = 1'b1;
                  cnt_d      = 4'd0;
                  state_d    = ST_WR_ACK;
               end
            end
            ST_RD_BYTE: if (hold_done) begin
               if (cnt_q == 4'd8) begin
                  sda_drv_d = 1'b0;
                  ack_d     = 1'b0;
                  state_d   = ST_RD_ACK;
               end else begin
                  sda_drv_d = ~tx_sh_q[7];
                  tx_sh_d   = {tx_sh_q[6:0], 1'b0};
                  cnt_d     = cnt_inc;
               end
            end
            ST_RD_ACK: begin
               if (scl_rise) begin
                  if (sda_s2_q) state_d = ST_IGNORE;
                  else          ack_d   = 1'b1;
               end else if (hold_done && ack_q) begin
                  load_tx = 1'b1;
               end
            end
            default: ;
         endcase
      end
      // Bit 7 goes out with the latch; the counter tracks bits already driven.
      if (load_tx) begin
         tx_sh_d   = {tx_data[6:0], 1'b0};
         sda_drv_d = ~tx_data[7];
         tx_req_d  = 1'b1;
         cnt_d     = 4'd1;
         state_d   = ST_RD_BYTE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 4'd0;
         sh_q      <= '0;
         tx_sh_q   <= '0;
         rx_data   <= '0;
         sda_drv_q <= 1'b0;
         busy      <= 1'b0;
         rw        <= 1'b0;
         ack_q     <= 1'b0;
         rx_valid  <= 1'b0;
         tx_req    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sh_q      <= sh_d;
         tx_sh_q   <= tx_sh_d;
         rx_data   <= rx_data_d;
         sda_drv_q <= sda_drv_d;
         busy      <= busy_d;
         rw        <= rw_d;
         ack_q     <= ack_d;
         rx_valid  <= rx_valid_d;
         tx_req    <= tx_req_d;
      end
   end

endmodule

// File: tb/tb_i2c_target_responder.sv
// Directed bench for i2c_target_responder: bit-banged master on a pulled-up SDA line.
`timescale 1ns/1ps
module tb_i2c_target_responder;

   localparam int Q = 40;  // quarter SCL period in clk cycles (16 MHz clk, 100 kHz SCL)

   logic       clk = 1'b0;
   logic       reset;
   logic       scl;
   logic       m_low;
   logic [7:0] tx_data;
   logic       tx_req, rx_valid, busy, rw;
   logic [7:0] rx_data;
   wire        sda_bus;

   assign sda_bus = m_low ? 1'b0 : 1'bz;
   pullup (sda_bus);

   always #31.25 clk = ~clk;

   i2c_target_responder dut (
      .clk      (clk),
      .reset    (reset),
      .i2c_sclk (scl),
      .i2c_sdat (sda_bus),
      .tx_data  (tx_data),
      .tx_req   (tx_req),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .busy     (busy),
      .rw       (rw)
   );

   int n_vec = 0, n_err = 0;
   int rx_cnt = 0, tx_cnt = 0, drv_cnt = 0, both_cnt = 0;

   always @(negedge clk) begin
      if (rx_valid) rx_cnt <= rx_cnt + 1;
      if (tx_req) tx_cnt <= tx_cnt + 1;
      if (rx_valid && tx_req) both_cnt <= both_cnt + 1;
      if (!m_low && sda_bus === 1'b0) drv_cnt <= drv_cnt + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clock_bit(input logic b, output logic seen);
      m_low = ~b;
      wait_clk(Q);
      scl = 1'b1;
      wait_clk(Q);
      seen = sda_bus;
      wait_clk(Q);
      scl = 1'b0;
      wait_clk(Q);
   endtask

   task automatic start_cond();
      m_low = 1'b0;
      wait_clk(Q);
      scl = 1'b1;
      wait_clk(Q);
      m_low = 1'b1;
      wait_clk(Q);
      scl = 1'b0;
      wait_clk(Q);
   endtask

   task automatic stop_cond();
      m_low = 1'b1;
      wait_clk(Q);
      scl = 1'b1;
      wait_clk(Q);
      m_low = 1'b0;
      wait_clk(Q);
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
      clock_bit(1'b1, ack);
   endtask

   task automatic read_byte(input logic mack, input logic [7:0] next_tx,
                            output logic [7:0] d, output logic ack_seen);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         clock_bit(1'b1, s);
         d[i] = s;
      end
      tx_data = next_tx;
      clock_bit(mack, ack_seen);
   endtask

   initial begin
      #20ms;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       ack, a;
      logic [7:0] d, d2;
      int         r0, t0, dr0;

      reset   = 1'b1;
      scl     = 1'b1;
      m_low   = 1'b0;
      tx_data = 8'h00;
      wait_clk(5);
      check_eq("rst_sda", sda_bus, 1'b1);
      check_eq("rst_busy", busy, 1'b0);
      reset = 1'b0;
      wait_clk(5);
      check_eq("rst_rw", rw, 1'b0);
      check_eq("rst_rx_data", rx_data, 8'h00);
      check_eq("rst_rx_valid", rx_valid, 1'b0);
      check_eq("rst_tx_req", tx_req, 1'b0);

      // Write 0xA5 to 0x27
      r0 = rx_cnt;
      start_cond();
      send_byte(8'h4E, ack);
      check_eq("wr_addr_ack", ack, 1'b0);
      check_eq("wr_busy", busy, 1'b1);
      check_eq("wr_rw", rw, 1'b0);
      send_byte(8'hA5, ack);
      check_eq("wr_data_ack", ack, 1'b0);
      check_eq("wr_rx_count", rx_cnt - r0, 1);
      check_eq("wr_rx_data", rx_data, 8'hA5);
      stop_cond();
      wait_clk(10);
      check_eq("wr_busy_after_stop", busy, 1'b0);

      // Single-byte read, master NACK
      tx_data = 8'h3C;
      t0 = tx_cnt;
      start_cond();
      send_byte(8'h4F, ack);
      check_eq("rd_addr_ack", ack, 1'b0);
      check_eq("rd_rw", rw, 1'b1);
      read_byte(1'b1, 8'hFF, d, a);
      check_eq("rd_byte", d, 8'h3C);
      check_eq("rd_nack_released", a, 1'b1);
      check_eq("rd_busy_before_stop", busy, 1'b1);
      check_eq("rd_tx_req_count", tx_cnt - t0, 1);
      stop_cond();
      wait_clk(10);
      check_eq("rd_busy_after_stop", busy, 1'b0);

      // Two-byte read: ACK then NACK
      tx_data = 8'h81;
      t0 = tx_cnt;
      start_cond();
      send_byte(8'h4F, ack);
      check_eq("rd2_addr_ack", ack, 1'b0);
      read_byte(1'b0, 8'h7E, d, a);
      read_byte(1'b1, 8'h00, d2, a);
      check_eq("rd2_byte0", d, 8'h81);
      check_eq("rd2_byte1", d2, 8'h7E);
      check_eq("rd2_tx_req_count", tx_cnt - t0, 2);
      stop_cond();
      wait_clk(10);
      check_eq("rd2_busy_after_stop", busy, 1'b0);

      // Address mismatch
      r0  = rx_cnt;
      dr0 = drv_cnt;
      start_cond();
      send_byte(8'hA0, ack);
      check_eq("mm_addr_nack", ack, 1'b1);
      check_eq("mm_busy", busy, 1'b0);
      send_byte(8'h55, ack);
      check_eq("mm_data_nack", ack, 1'b1);
      stop_cond();
      wait_clk(10);
      check_eq("mm_rx_count", rx_cnt - r0, 0);
      check_eq("mm_sda_driven", drv_cnt - dr0, 0);
      check_eq("mm_busy_after_stop", busy, 1'b0);

      // Repeated START after 4 data bits, then read
      r0 = rx_cnt;
      tx_data = 8'h96;
      start_cond();
      send_byte(8'h4E, ack);
      check_eq("rs_wr_addr_ack", ack, 1'b0);
      clock_bit(1'b1, a);
      clock_bit(1'b0, a);
      clock_bit(1'b1, a);
      clock_bit(1'b0, a);
      start_cond();
      send_byte(8'h4F, ack);
      check_eq("rs_rd_addr_ack", ack, 1'b0);
      check_eq("rs_rx_count", rx_cnt - r0, 0);
      check_eq("rs_rw", rw, 1'b1);
      read_byte(1'b1, 8'h00, d, a);
      check_eq("rs_rd_byte", d, 8'h96);
      stop_cond();
      wait_clk(10);
      check_eq("rs_busy_after_stop", busy, 1'b0);

      // Reset while the target drives a 0 data bit
      tx_data = 8'h3C;
      start_cond();
      send_byte(8'h4F, ack);
      check_eq("rr_addr_ack", ack, 1'b0);
      check_eq("rr_bit7_driven", sda_bus, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_eq("rr_sda_released", sda_bus, 1'b1);
      check_eq("rr_busy", busy, 1'b0);
      check_eq("rr_rw", rw, 1'b0);
      check_eq("rr_rx_data", rx_data, 8'h00);
      check_eq("rr_rx_valid", rx_valid, 1'b0);
      check_eq("rr_tx_req", tx_req, 1'b0);
      wait_clk(3);
      reset = 1'b0;
      dr0 = drv_cnt;
      t0  = tx_cnt;
      for (int i = 0; i < 3; i++) clock_bit(1'b1, a);
      check_eq("rr_idle_no_drive", drv_cnt - dr0, 0);
      check_eq("rr_idle_no_tx_req", tx_cnt - t0, 0);
      check_eq("rr_idle_busy", busy, 1'b0);
      stop_cond();

      // Recovery write after reset
      start_cond();
      send_byte(8'h4E, ack);
      check_eq("rc_addr_ack", ack, 1'b0);
      send_byte(8'h5A, ack);
      check_eq("rc_data_ack", ack, 1'b0);
      check_eq("rc_rx_data", rx_data, 8'h5A);
      stop_cond();
      wait_clk(10);
      check_eq("rc_busy_after_stop", busy, 1'b0);
      check_eq("no_rx_tx_overlap", both_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
